// File: rtl/usb_txenc.sv
// usb_txenc: USB transmit line encoder.
// Emits SYNC, LSB-first NRZI data with bit stuffing, and EOP on D+/D-.
module usb_txenc #(
    parameter int CLK_PER_BIT = 4,
    parameter int LOW_SPEED   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       dp,
    output logic       dn,
    output logic       oe,
    output logic       busy,
    output logic       err_underrun
);

    localparam int DW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_PER_BIT - 1);
    localparam logic J_DP = (LOW_SPEED == 0);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        ABORT,
        EOP
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [2:0]    bit_q, bit_d;
    logic [2:0]    ones_q, ones_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          last_q, last_d;
    logic          lvl_q, lvl_d;
    logic          se0_q, se0_d;
    logic          oe_q, oe_d;
    logic          err_q, err_d;
    logic          dp_q, dp_d;
    logic          dn_q, dn_d;

    logic strobe;
    logic stuff;
    logic byte_end;
    logic fetch;

    // One bit of NRZI: a 1 holds the level (J=1) and extends the run
    function automatic logic [3:0] nrzi(
        input logic       b,
        input logic       lvl,
        input logic [2:0] ones
    );
        return b ? {lvl, ones + 3'd1} : {~lvl, 3'd0};
    endfunction

    assign strobe   = (div_q == DIV_MAX);
    assign stuff    = (ones_q == 3'd6);
    assign byte_end = (bit_q == 3'd7) && !stuff;
    assign fetch    = (state_q == DATA) && strobe && byte_end && !last_q;

    assign tx_ready     = !rst && ((state_q == IDLE) || fetch);
    assign dp           = dp_q;
    assign dn           = dn_q;
    assign oe           = oe_q;
    assign busy         = (state_q != IDLE);
    assign err_underrun = err_q;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            ones_q  <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            last_q  <= 1'b0;
            lvl_q   <= 1'b1;
            se0_q   <= 1'b0;
            oe_q    <= 1'b0;
            err_q   <= 1'b0;
            dp_q    <= J_DP;
            dn_q    <= ~J_DP;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            ones_q  <= ones_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            last_q  <= last_d;
            lvl_q   <= lvl_d;
            se0_q   <= se0_d;
            oe_q    <= oe_d;
            err_q   <= err_d;
            dp_q    <= dp_d;
            dn_q    <= dn_d;
        end
    end

    // Next state: transitions happen only on a bit strobe, except leaving IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (tx_valid) state_d = SYNC;
            end
            SYNC: begin
                if (strobe && bit_q == 3'd7) state_d = DATA;
            end
            DATA: begin
                if (strobe && byte_end) begin
                    if (last_q)         state_d = EOP;
                    else if (!tx_valid) state_d = ABORT;
                end
            end
            ABORT: begin
                if (strobe && cnt_q == 3'd6) state_d = EOP;
            end
            EOP: begin
                if (strobe && cnt_q == 3'd2) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs and datapath: each strobe decides what the next bit period shows
    always_comb begin
        div_d   = (state_q == IDLE || strobe) ? '0 : div_q + DW'(1);
        bit_d   = bit_q;
        ones_d  = ones_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        last_d  = last_q;
        lvl_d   = lvl_q;
        se0_d   = se0_q;
        oe_d    = oe_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                lvl_d = 1'b1;
                se0_d = 1'b0;
                oe_d  = 1'b0;
                if (tx_valid) begin
                    shift_d = tx_data;
                    last_d  = tx_last;
                    bit_d   = 3'd0;
                    ones_d  = 3'd0;
                    lvl_d   = 1'b0;
                    oe_d    = 1'b1;
                end
            end
            SYNC: begin
                if (strobe) begin
                    if (bit_q == 3'd7) begin
                        bit_d = 3'd0;
                        {lvl_d, ones_d} = nrzi(shift_q[0], lvl_q, ones_q);
                    end else begin
                        bit_d = bit_q + 3'd1;
                        {lvl_d, ones_d} = nrzi(bit_q == 3'd6, lvl_q, ones_q);
                    end
                end
            end
            DATA: begin
                if (strobe) begin
                    if (stuff) begin
                        lvl_d  = ~lvl_q;
                        ones_d = 3'd0;
                    end else if (bit_q != 3'd7) begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 3'd1;
                        {lvl_d, ones_d} = nrzi(shift_q[1], lvl_q, ones_q);
                    end else if (last_q) begin
                        se0_d = 1'b1;
                        cnt_d = 3'd0;
                    end else if (tx_valid) begin
                        shift_d = tx_data;
                        last_d  = tx_last;
                        bit_d   = 3'd0;
                        {lvl_d, ones_d} = nrzi(tx_data[0], lvl_q, ones_q);
                    end else begin
                        err_d = 1'b1;
                        cnt_d = 3'd0;
                    end
                end
            end
            ABORT: begin
                if (strobe) begin
                    if (cnt_q == 3'd6) begin
                        se0_d = 1'b1;
                        cnt_d = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            EOP: begin
                if (strobe) begin
                    if (cnt_q == 3'd1) begin
                        se0_d = 1'b0;
                        lvl_d = 1'b1;
                    end
                    if (cnt_q == 3'd2) begin
                        oe_d    = 1'b0;
                        cnt_d   = 3'd0;
                        bit_d   = 3'd0;
                        ones_d  = 3'd0;
                        shift_d = 8'h00;
                        last_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                oe_d = 1'b0;
            end
        endcase
        dp_d = se0_d ? 1'b0 : (lvl_d ? J_DP : ~J_DP);
        dn_d = se0_d ? 1'b0 : (lvl_d ? ~J_DP : J_DP);
    end

endmodule

// File: tb/tb_usb_txenc.sv
// tb_usb_txenc: directed and random packets on an FS and an LS encoder.
// Line traces are compared against a bit-list reference encoder.
module tb_usb_txenc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       v0, l0, v1, l1;
    logic [7:0] d0, d1;
    logic       r0, dp0, dn0, oe0, b0, e0;
    logic       r1, dp1, dn1, oe1, b1, e1;

    usb_txenc #(.CLK_PER_BIT(4), .LOW_SPEED(0)) u_fs (
        .clk(clk), .rst(rst),
        .tx_valid(v0), .tx_data(d0), .tx_last(l0), .tx_ready(r0),
        .dp(dp0), .dn(dn0), .oe(oe0), .busy(b0), .err_underrun(e0)
    );

    usb_txenc #(.CLK_PER_BIT(1), .LOW_SPEED(1)) u_ls (
        .clk(clk), .rst(rst),
        .tx_valid(v1), .tx_data(d1), .tx_last(l1), .tx_ready(r1),
        .dp(dp1), .dn(dn1), .oe(oe1), .busy(b1), .err_underrun(e1)
    );

    int vec  = 0;
    int miss = 0;
    int xf0  = 0;
    int xf1  = 0;
    int ec0  = 0;
    int ec1  = 0;

    logic [1:0] tr0[$];
    logic [1:0] tr1[$];
    logic [1:0] exp_q[$];
    logic [7:0] pkt_q[$];

    always @(negedge clk) begin
        if (oe0) tr0.push_back({dp0, dn0});
        if (oe1) tr1.push_back({dp1, dn1});
        if (e0) ec0++;
        if (e1) ec1++;
    end

    always @(posedge clk) begin
        if (v0 && r0) xf0++;
        if (v1 && r1) xf1++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp, output bit ok);
        vec++;
        ok = (obs === exp);
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: build the bit list, stuff after six 1s, NRZI, then EOP
    task automatic build_exp(input bit ls, input int cpb, input bit abort);
        int         bits[$];
        int         run;
        bit         b;
        bit         lvl;
        logic [1:0] j;
        logic [1:0] k;
        exp_q.delete();
        for (int i = 0; i < 8; i++) bits.push_back(i == 7 ? 1 : 0);
        run = 1;
        foreach (pkt_q[n]) begin
            for (int i = 0; i < 8; i++) begin
                b = pkt_q[n][i];
                bits.push_back(b ? 1 : 0);
                run = b ? run + 1 : 0;
                if (run == 6) begin
                    bits.push_back(0);
                    run = 0;
                end
            end
        end
        if (abort) repeat (7) bits.push_back(1);
        j   = ls ? 2'b01 : 2'b10;
        k   = ~j;
        lvl = 1'b1;
        foreach (bits[i]) begin
            if (bits[i] == 0) lvl = ~lvl;
            repeat (cpb) exp_q.push_back(lvl ? j : k);
        end
        repeat (2 * cpb) exp_q.push_back(2'b00);
        repeat (cpb) exp_q.push_back(j);
    endtask

    task automatic set_in(input bit s, input logic v,
                          input logic [7:0] d, input logic l);
        if (s) begin
            v1 = v; d1 = d; l1 = l;
        end else begin
            v0 = v; d0 = d; l0 = l;
        end
    endtask

    // Send pkt_q on one encoder; abort drops tx_valid after the last byte
    task automatic send(input bit s, input bit abort, input string tag,
                        output int len);
        int         n;
        int         tb;
        int         xb;
        int         eb;
        int         wc;
        int         got;
        bit         ok;
        logic [1:0] sym;
        logic [1:0] j;
        n  = pkt_q.size();
        tb = s ? tr1.size() : tr0.size();
        xb = s ? xf1 : xf0;
        eb = s ? ec1 : ec0;
        j  = s ? 2'b01 : 2'b10;
        build_exp(s, s ? 1 : 4, abort);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            set_in(s, 1'b1, pkt_q[i], !abort && i == n - 1);
            #1;
            wc = 0;
            while (!(s ? r1 : r0) && wc < 400) begin
                @(negedge clk);
                #1;
                wc++;
            end
            if (wc >= 400) begin
                chk({tag, " ready timeout"}, 0, 1, ok);
                break;
            end
            @(negedge clk);
        end
        set_in(s, 1'b0, 8'h00, 1'b0);
        wc = 0;
        while ((s ? b1 : b0) && wc < 3000) begin
            @(negedge clk);
            wc++;
        end
        chk({tag, " busy timeout"}, 32'(wc >= 3000), 0, ok);
        @(negedge clk);
        len = (s ? tr1.size() : tr0.size()) - tb;
        chk({tag, " oe length"}, len, exp_q.size(), ok);
        for (int i = 0; i < exp_q.size() && i < len; i++) begin
            sym = s ? tr1[tb + i] : tr0[tb + i];
            chk($sformatf("%s line cycle %0d", tag, i), sym, exp_q[i], ok);
            if (!ok) break;
        end
        got = (s ? xf1 : xf0) - xb;
        chk({tag, " transfers"}, got, n, ok);
        got = (s ? ec1 : ec0) - eb;
        chk({tag, " underrun pulses"}, got, abort ? 1 : 0, ok);
        chk({tag, " idle line"}, s ? {dp1, dn1} : {dp0, dn0}, j, ok);
        chk({tag, " idle oe"}, s ? oe1 : oe0, 0, ok);
    endtask

    initial begin
        bit ok;
        int len;
        int n;
        bit ab;
        rst = 1'b1;
        set_in(0, 1'b0, 8'h00, 1'b0);
        set_in(1, 1'b0, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset oe fs", oe0, 0, ok);
        chk("reset busy fs", b0, 0, ok);
        chk("reset err fs", e0, 0, ok);
        chk("reset line fs", {dp0, dn0}, 2'b10, ok);
        chk("idle ready fs", r0, 1, ok);
        chk("reset line ls", {dp1, dn1}, 2'b01, ok);
        chk("reset oe ls", oe1, 0, ok);

        @(negedge clk);
        rst = 1'b1;
        set_in(0, 1'b1, 8'h00, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        set_in(0, 1'b0, 8'h00, 1'b0);
        chk("rst beats valid busy", b0, 0, ok);
        chk("rst beats valid oe", oe0, 0, ok);

        pkt_q = '{8'h00};
        send(0, 0, "s1 0x00", len);
        chk("s1 oe cycles", len, 76, ok);

        pkt_q = '{8'hFF};
        send(0, 0, "s2 0xFF", len);
        chk("s2 oe cycles", len, 80, ok);

        pkt_q = '{8'hA5, 8'h3C};
        send(0, 0, "s3 A5 3C", len);
        chk("s3 oe cycles", len, 108, ok);

        pkt_q = '{8'h01};
        send(0, 1, "s4 underrun", len);
        chk("s4 oe cycles", len, 104, ok);

        @(negedge clk);
        set_in(0, 1'b1, 8'h55, 1'b0);
        @(negedge clk);
        set_in(0, 1'b0, 8'h00, 1'b0);
        repeat (40) @(negedge clk);
        chk("s5 busy before rst", b0, 1, ok);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("s5 rst oe", oe0, 0, ok);
        chk("s5 rst busy", b0, 0, ok);
        chk("s5 rst line", {dp0, dn0}, 2'b10, ok);
        pkt_q = '{8'h00};
        send(0, 0, "s5 after rst", len);
        chk("s5 oe cycles", len, 76, ok);

        pkt_q = '{8'h00};
        send(1, 0, "s6 ls 0x00", len);
        chk("s6 oe cycles", len, 19, ok);

        for (int p = 0; p < 10; p++) begin
            pkt_q.delete();
            n  = $urandom_range(1, 4);
            ab = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) pkt_q.push_back(8'hFF);
                else pkt_q.push_back(8'($urandom));
            end
            send(p >= 6, ab, $sformatf("rnd%0d", p), len);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/usb_txenc.md
# usb_txenc

Synthesizable, parametrised USB transmit line encoder; the hardware successor to the bench's behavioural encoder model. It accepts packet bytes over a valid/ready stream from the transaction layer (usb_devtrsac) and drives the D+/D- lines. It generates SYNC, LSB-first NRZI data with bit stuffing, and EOP. It is generalised in bit rate (clock divider), speed polarity (FS/LS), and it handles an underrun abort.

## Interface

Parameters:
- CLK_PER_BIT, 4, clock cycles per USB bit time; legal range ≥1 (4 gives FS at 48 MHz).
- LOW_SPEED, 0, 0 selects FS line polarity (J: dp=1, dn=0); 1 selects LS polarity (J: dp=0, dn=1).

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- tx_valid  in  1  a byte is offered on tx_data.
- tx_data  in  8  packet byte, sent LSB first.
- tx_last  in  1  qualifies tx_data as the final byte of the packet.
- tx_ready  out  1  combinational; a transfer occurs on the edge where tx_valid && tx_ready.
- dp, dn  out  1 each  registered line levels.
- oe  out  1  registered line-driver enable.
- busy  out  1  high whenever the state is not IDLE.
- err_underrun  out  1  one-cycle registered pulse when a byte is needed and not available.

## Operation

- Reset and idle values: state IDLE; oe=0, dp/dn=J, busy=0, err_underrun=0; bit counter, ones counter and shifter all cleared. Reset mid-packet applies these values on the next edge, with no EOP sent.
- Bit strobe: the divider counts 0..CLK_PER_BIT-1; a strobe fires when count==CLK_PER_BIT-1. Outputs change only when a bit period starts.
- NRZI encoding: a 0 toggles the line between J and K; a 1 holds the line.
- FSM states: IDLE, SYNC, DATA, ABORT, EOP.
- IDLE: tx_ready=1. On a transfer, the FSM latches the byte and tx_last and moves to SYNC.
- SYNC: sends 8 bits 00000001, which appears on the line as KJKJKJKK. The ones counter leaves SYNC at 1, because the final SYNC 1 counts toward stuffing. Moves to DATA.
- DATA: shifts 8 bits per byte.
  - The ones counter increments on each 1 and clears on each 0.
  - When the counter reaches 6, the next bit period carries an inserted 0 (a toggle) and the counter clears.
  - Stuffing also applies after the final data bit, before EOP.
- Next-byte fetch: tx_ready=1 only during the strobe cycle of bit 7, and only when no stuff bit is pending and the current byte is not last.
  - Transfer: load the new byte; DATA continues with no gap.
  - tx_valid=0: pulse err_underrun and go to ABORT.
- ABORT: sends 7 bit times of 1 with stuffing disabled, so the line holds still for 7 bit times. Then moves to EOP.
- EOP: drives SE0 (dp=dn=0) for 2 bit times, then J for 1 bit time, then returns to IDLE.
  - oe drops on the cycle the FSM enters IDLE.
  - EOP is entered after bit 7 of the last byte plus any pending stuff bit.
- tx_ready is 0 in SYNC, ABORT and EOP. A transfer is accepted only at the points listed above.

## Timing

- Start: a transfer in IDLE at edge t gives oe=1, busy=1 and line=K in the cycle after t. Each bit lasts CLK_PER_BIT cycles.
- Packet length: oe stays high for exactly (8 + 8N + S + 3)·CLK_PER_BIT cycles, where N is the byte count and S is the number of stuffed bits.
- Back-to-back packets: the FSM returns to IDLE, and the next packet's SYNC starts no earlier than the cycle after the transfer accepted in IDLE.
- CLK_PER_BIT=1: the strobe is high every cycle, and tx_ready is high for exactly one cycle per byte.
- Simultaneous rst and tx_valid: rst wins and no transfer occurs.

## Test plan

- Single byte 0x00 with tx_last=1, CLK_PER_BIT=4: the line shows KJKJKJKK, JKJKJKJK, SE0, SE0, J. oe is high for 76 cycles, with exactly one tx_ready transfer.
- Single byte 0xFF with tx_last=1: a stuffed 0 follows data bit 4 (the fifth 1), so S=1. The line shows KJKJKJKK, KKKKK, J, JJJ, SE0, SE0, J. oe is high for 80 cycles.
- Bytes 0xA5 then 0x3C with tx_valid held high: the second transfer lands on the bit-7 strobe of the first byte. There is no idle gap, and the NRZI sequence matches a reference encoder bit-for-bit. oe is high for 27·4 cycles.
- Underrun: send 0x01 with tx_last=0, then drop tx_valid. err_underrun pulses exactly once. The line then holds static for 7 bit times, followed by SE0, SE0, J, and busy returns to 0.
- Reset mid-DATA: assert rst for 1 cycle. On the next cycle oe=0, dp/dn=J, busy=0. A following 0x00 packet matches scenario 1 exactly.
- LOW_SPEED=1, CLK_PER_BIT=1: idle is dp=0, dn=1. Scenario 1 reproduces with inverted J/K and oe high for 19 cycles.
